// File: rtl/risc_pkg.sv
// Shared encodings for the fetch stage and pipeline registers.
package risc_pkg;
  localparam logic [15:0] NOP_INSTR    = 16'h0000;
  localparam int          IMM_FLAG_BIT = 15;
  localparam int          RSRC_LSB     = 5;
  localparam int          RDST_LSB     = 8;
  localparam int          REG_W        = 3;

  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with hold and clear-to-NOP controls; clear has priority over hold.
module if_id_reg
  import risc_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_hold,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [INSTR_W-1:0] i_imm,
  input  logic [PC_W-1:0]    i_pc,
  input  logic               i_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [INSTR_W-1:0] o_imm,
  output logic [PC_W-1:0]    o_pc,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [INSTR_W-1:0] r_imm;
  logic [PC_W-1:0]    r_pc;
  logic               r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= INSTR_W'(NOP_INSTR);
      r_imm   <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_instr <= INSTR_W'(NOP_INSTR);
      r_imm   <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      r_instr <= i_instr;
      r_imm   <= i_imm;
      r_pc    <= i_pc;
      r_valid <= i_valid;
    end
  end

  assign o_instr = r_instr;
  assign o_imm   = r_imm;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, one/two-word fetch FSM and IF/ID register.
// Optional stall/flush statistics counters are built when IF_STAT_EN is defined.
//   state | meaning
//   S_OP  | expecting an opcode word at pc
//   S_IMM | opcode held, expecting its immediate word at pc
module fetch_unit
  import risc_pkg::*;
#(
  parameter int          PC_W     = 16,
  parameter int          INSTR_W  = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_fetch,
  input  logic               flush_fetch,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_instr,
  output logic [INSTR_W-1:0] if_imm,
  output logic [PC_W-1:0]    if_pc,
  output logic               if_valid,
  output logic [REG_W-1:0]   R_src_fetch,
  output logic [REG_W-1:0]   R_dest_fetch
`ifdef IF_STAT_EN
  ,
  output logic [15:0]        stat_stall_cnt,
  output logic [15:0]        stat_flush_cnt
`endif
);

  fetch_state_t       r_state, w_state_nxt;
  logic [PC_W-1:0]    r_pc, w_pc_nxt;
  logic [INSTR_W-1:0] r_hold_instr, w_hold_instr_nxt;
  logic [PC_W-1:0]    r_hold_pc, w_hold_pc_nxt;

  logic               w_imm_flag;
  logic               w_ifid_hold, w_ifid_clear, w_ifid_valid;
  logic [INSTR_W-1:0] w_ifid_instr, w_ifid_imm;
  logic [PC_W-1:0]    w_ifid_pc;

  assign w_imm_flag = imem_rdata[IMM_FLAG_BIT];
  assign imem_addr  = r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_OP;
      r_pc         <= PC_W'(RESET_PC);
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_hold_instr <= w_hold_instr_nxt;
      r_hold_pc    <= w_hold_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_hold_instr_nxt = r_hold_instr;
    w_hold_pc_nxt    = r_hold_pc;
    if (flush_fetch) begin
      w_state_nxt      = S_OP;
      w_pc_nxt         = branch_target;
      w_hold_instr_nxt = '0;
    end else if (!stall_fetch) begin
      w_pc_nxt = r_pc + 1'b1;
      if (r_state == S_IMM) begin
        w_state_nxt = S_OP;
      end else if (w_imm_flag) begin
        w_state_nxt      = S_IMM;
        w_hold_instr_nxt = imem_rdata;
        w_hold_pc_nxt    = r_pc;
      end
    end
  end

  // The opcode half of a two-word instruction leaves a bubble in IF/ID.
  always_comb begin
    w_ifid_hold  = 1'b0;
    w_ifid_clear = 1'b0;
    w_ifid_instr = imem_rdata;
    w_ifid_imm   = '0;
    w_ifid_pc    = r_pc;
    w_ifid_valid = 1'b1;
    if (flush_fetch) begin
      w_ifid_clear = 1'b1;
    end else if (stall_fetch) begin
      w_ifid_hold = 1'b1;
    end else if (r_state == S_IMM) begin
      w_ifid_instr = r_hold_instr;
      w_ifid_imm   = imem_rdata;
      w_ifid_pc    = r_hold_pc;
    end else if (w_imm_flag) begin
      w_ifid_clear = 1'b1;
    end
  end

  if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_hold  (w_ifid_hold),
    .i_clear (w_ifid_clear),
    .i_instr (w_ifid_instr),
    .i_imm   (w_ifid_imm),
    .i_pc    (w_ifid_pc),
    .i_valid (w_ifid_valid),
    .o_instr (if_instr),
    .o_imm   (if_imm),
    .o_pc    (if_pc),
    .o_valid (if_valid)
  );

  assign R_src_fetch  = if_instr[RSRC_LSB +: REG_W];
  assign R_dest_fetch = if_instr[RDST_LSB +: REG_W];

`ifdef IF_STAT_EN
  logic [15:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (flush_fetch && r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 1'b1;
      if (stall_fetch && !flush_fetch && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stat_stall_cnt = r_stall_cnt;
  assign stat_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios, then randomized stall/flush traffic.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall_fetch = 1'b0;
  logic        flush_fetch = 1'b0;
  logic [15:0] branch_target = 16'h0;
  logic [15:0] imem_addr, imem_rdata;
  logic [15:0] if_instr, if_imm, if_pc;
  logic        if_valid;
  logic [2:0]  R_src_fetch, R_dest_fetch;
`ifdef IF_STAT_EN
  logic [15:0] stat_stall_cnt, stat_flush_cnt;
`endif

  logic [15:0] mem [0:65535];
  assign imem_rdata = mem[imem_addr];

  fetch_unit #(.PC_W(16), .INSTR_W(16), .RESET_PC(0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_fetch   (stall_fetch),
    .flush_fetch   (flush_fetch),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .if_instr      (if_instr),
    .if_imm        (if_imm),
    .if_pc         (if_pc),
    .if_valid      (if_valid),
    .R_src_fetch   (R_src_fetch),
    .R_dest_fetch  (R_dest_fetch)
`ifdef IF_STAT_EN
    ,
    .stat_stall_cnt(stat_stall_cnt),
    .stat_flush_cnt(stat_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: architectural pc, a pending-opcode queue and the expected IF/ID contents.
  logic [15:0] m_pc, m_instr, m_imm, m_ifpc;
  logic        m_valid;
  logic [31:0] pend [$];
  int          m_stall_cnt, m_flush_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0; m_instr = 16'h0; m_imm = 16'h0; m_ifpc = 16'h0; m_valid = 1'b0;
    pend.delete();
    m_stall_cnt = 0; m_flush_cnt = 0;
  endtask

  task automatic model_step(input logic s, input logic f, input logic [15:0] bt);
    logic [31:0] e;
    logic [15:0] w;
    if (f) begin
      if (m_flush_cnt < 65535) m_flush_cnt++;
      m_pc = bt;
      pend.delete();
      m_instr = 16'h0; m_imm = 16'h0; m_ifpc = 16'h0; m_valid = 1'b0;
    end else if (s) begin
      if (m_stall_cnt < 65535) m_stall_cnt++;
    end else begin
      w = mem[m_pc];
      if (pend.size() != 0) begin
        e = pend.pop_front();
        m_instr = e[15:0]; m_ifpc = e[31:16]; m_imm = w; m_valid = 1'b1;
      end else if (w[15]) begin
        pend.push_back({m_pc, w});
        m_instr = 16'h0; m_imm = 16'h0; m_ifpc = 16'h0; m_valid = 1'b0;
      end else begin
        m_instr = w; m_imm = 16'h0; m_ifpc = m_pc; m_valid = 1'b1;
      end
      m_pc = m_pc + 16'h1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_instr"}, {16'h0, if_instr}, {16'h0, m_instr});
    chk({tag, "_imm"},   {16'h0, if_imm},   {16'h0, m_imm});
    chk({tag, "_pc"},    {16'h0, if_pc},    {16'h0, m_ifpc});
    chk({tag, "_valid"}, {31'h0, if_valid}, {31'h0, m_valid});
    chk({tag, "_src"},   {29'h0, R_src_fetch},  {29'h0, m_instr[7:5]});
    chk({tag, "_dest"},  {29'h0, R_dest_fetch}, {29'h0, m_instr[10:8]});
    chk({tag, "_addr"},  {16'h0, imem_addr}, {16'h0, m_pc});
`ifdef IF_STAT_EN
    chk({tag, "_nstall"}, {16'h0, stat_stall_cnt}, m_stall_cnt);
    chk({tag, "_nflush"}, {16'h0, stat_flush_cnt}, m_flush_cnt);
`endif
  endtask

  task automatic cyc(input logic s, input logic f, input logic [15:0] bt);
    stall_fetch = s; flush_fetch = f; branch_target = bt;
    model_step(s, f, bt);
    @(posedge clk); #1;
    check_all("cyc");
  endtask

  initial begin
    logic s, f;
    logic [15:0] bt;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0123; mem[1] = 16'h0456; mem[2] = 16'h8A20; mem[3] = 16'h1234;
    mem[4] = 16'h8555; mem[5] = 16'h2222; mem[16'h40] = 16'h0777;
    mem[16'hFFFF] = 16'h9ABC; mem[16'h10] = 16'h8111;

    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_instr", {16'h0, if_instr}, 32'h0);
    chk("rst_addr",  {16'h0, imem_addr}, 32'h0);
    check_all("rst");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    cyc(0, 0, 0);
    chk("w1_instr", {16'h0, if_instr}, 32'h0123);
    chk("w1_pc",    {16'h0, if_pc},    32'h0);
    chk("w1_valid", {31'h0, if_valid}, 32'h1);
    cyc(0, 0, 0);
    chk("w2_instr", {16'h0, if_instr}, 32'h0456);
    chk("w2_dest",  {29'h0, R_dest_fetch}, 32'd4);
    chk("w2_src",   {29'h0, R_src_fetch},  32'd2);

    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0);
      chk("stall_instr", {16'h0, if_instr}, 32'h0456);
      chk("stall_addr",  {16'h0, imem_addr}, 32'h2);
    end

    cyc(0, 0, 0);
    chk("two_bubble", {31'h0, if_valid}, 32'h0);
    cyc(0, 0, 0);
    chk("two_instr", {16'h0, if_instr}, 32'h8A20);
    chk("two_imm",   {16'h0, if_imm},   32'h1234);
    chk("two_pc",    {16'h0, if_pc},    32'h2);
    chk("two_addr",  {16'h0, imem_addr}, 32'h4);

    cyc(0, 0, 0);
    cyc(1, 1, 16'h0040);
    chk("flush_valid", {31'h0, if_valid}, 32'h0);
    chk("flush_instr", {16'h0, if_instr}, 32'h0);
    chk("flush_addr",  {16'h0, imem_addr}, 32'h40);
    cyc(0, 0, 0);
    chk("flush_tgt_instr", {16'h0, if_instr}, 32'h0777);
    chk("flush_tgt_pc",    {16'h0, if_pc},    32'h40);

    cyc(0, 1, 16'hFFFF);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("wrap_pc",   {16'h0, if_pc},    32'hFFFF);
    chk("wrap_imm",  {16'h0, if_imm},   32'h0123);
    chk("wrap_addr", {16'h0, imem_addr}, 32'h1);

    cyc(0, 1, 16'h0010);
    cyc(0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_addr",  {16'h0, imem_addr}, 32'h0);
    chk("arst_valid", {31'h0, if_valid},  32'h0);
    check_all("arst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(0, 0, 0);
    chk("arst_restart", {16'h0, if_instr}, 32'h0123);

    for (int k = 0; k < 5; k++) cyc(1, 0, 0);
    cyc(0, 1, 16'h0020);
    cyc(1, 1, 16'h0030);
`ifdef IF_STAT_EN
    chk("stat_stall", {16'h0, stat_stall_cnt}, 32'd5);
    chk("stat_flush", {16'h0, stat_flush_cnt}, 32'd2);
`endif

    for (int k = 0; k < 3000; k++) begin
      s  = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 11) == 0);
      bt = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7))
                                       : 16'($urandom);
      cyc(s, f, bt);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
